// File: rtl/syzygy_adc_capture_if.sv
// ----------------------------------------------------------------------------
// syzygy_adc_capture_if
//   Stream bus carrying packed ADC words from the capture block to the host
//   transfer logic.
//
// Handshake: a word transfers on any rising clk edge where tvalid and tready
// are both 1. Once tvalid is raised it stays high, and tdata and tlast stay
// constant, until that transfer happens. tready may change at any time and
// does not depend on tvalid.
//
// Signals:
//   tdata  [31:0]  packed word: [15:0] earlier sample, [31:16] later sample
//   tvalid         word valid (driven by master)
//   tready         sink ready (driven by slave)
//   tlast          final word of a capture (driven by master)
// ----------------------------------------------------------------------------
interface syzygy_adc_capture_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/syzygy_adc_capture.sv
// ----------------------------------------------------------------------------
// syzygy_adc_capture
//   Armed, triggered capture of consecutive SYZYGY ADC samples. Samples are
//   packed two per 32-bit word, buffered, and streamed out on a valid/ready
//   bus.
//
// Ports:
//   clk, reset_n       clock (same as ADC encode), async active-low reset
//   adc_data/adc_valid ADC sample and qualifier
//   arm                single-cycle arm pulse (honoured in IDLE/DONE only)
//   sw_trigger         software trigger, level-sensitive while ARMED
//   trig_en            1 = wait for a trigger, 0 = start on first valid sample
//   trig_level         rising-crossing threshold
//   capture_len        samples per capture, latched on arm
//   m                  packed word stream (master side)
//   busy, done         registered status: ARMED|CAPTURE, DONE
//   overflow           sticky: a packed word was dropped on a full buffer
//   sample_count       samples taken in the current capture
//   state_dbg          current FSM state, for observation
// ----------------------------------------------------------------------------
module syzygy_adc_capture #(
    parameter int DATA_WIDTH = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   adc_data,
    input  logic                    adc_valid,
    input  logic                    arm,
    input  logic                    sw_trigger,
    input  logic                    trig_en,
    input  logic [DATA_WIDTH-1:0]   trig_level,
    input  logic [15:0]             capture_len,
    syzygy_adc_capture_if.master    m,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [15:0]             sample_count,
    output logic [1:0]              state_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t state, state_next;

    // capture control
    logic [15:0]           cap_len;
    logic [15:0]           pack_lo;
    logic [15:0]           sample16;
    logic [DATA_WIDTH-1:0] prev_sample;
    logic                  have_prev;
    logic                  crossing;
    logic                  trigger;
    logic                  arm_accept;
    logic                  take;
    logic                  final_smp;
    logic                  word_done;

    // registered push request: the completed word enters the buffer one edge
    // after its last sample is taken
    logic                  push_q;
    logic                  push_last_q;
    logic [31:0]           push_data_q;

    // buffer: memory plus the output register, which together hold at most
    // FIFO_DEPTH words
    logic [32:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         mem_count;
    logic [CW-1:0]         occ;
    logic                  pop, load, space, wr, drop;

    assign sample16   = 16'(adc_data);
    assign arm_accept = arm && (state == ST_IDLE || state == ST_DONE);

    // A crossing needs a previous valid sample seen while ARMED, so the first
    // valid sample after arming can only start a capture via sw_trigger.
    assign crossing = have_prev && (prev_sample < trig_level) && (adc_data >= trig_level);
    assign trigger  = adc_valid && (!trig_en || sw_trigger || crossing);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_ARMED) || (state_next == ST_CAPTURE);
            done  <= (state_next == ST_DONE);
        end
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        final_smp  = 1'b0;
        word_done  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_next = (capture_len == 16'd0) ? ST_DONE : ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (trigger) begin
                    take       = 1'b1;
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (adc_valid) begin
                    take = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // An odd-index sample completes a word; the final sample always does.
        if (take) begin
            final_smp = ((sample_count + 16'd1) == cap_len);
            word_done = sample_count[0] || final_smp;
            if (final_smp) begin
                state_next = ST_DONE;
            end
        end
    end

    assign state_dbg = state;

    // ------------------------------------------------------ capture datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_len      <= 16'd0;
            sample_count <= 16'd0;
            pack_lo      <= 16'd0;
            prev_sample  <= '0;
            have_prev    <= 1'b0;
            push_q       <= 1'b0;
            push_last_q  <= 1'b0;
            push_data_q  <= 32'd0;
        end else begin
            push_q <= 1'b0;
            if (arm_accept) begin
                cap_len      <= capture_len;
                sample_count <= 16'd0;
                pack_lo      <= 16'd0;
            end
            if (state == ST_ARMED) begin
                if (adc_valid) begin
                    have_prev   <= 1'b1;
                    prev_sample <= adc_data;
                end
            end else begin
                have_prev <= 1'b0;
            end
            if (take) begin
                sample_count <= sample_count + 16'd1;
                if (!sample_count[0]) begin
                    pack_lo <= sample16;
                end
                if (word_done) begin
                    push_q      <= 1'b1;
                    push_last_q <= final_smp;
                    push_data_q <= sample_count[0] ? {sample16, pack_lo}
                                                   : {16'd0, sample16};
                end
            end
        end
    end

    // -------------------------------------------------------- output buffer
    assign pop   = m.tvalid && m.tready;
    // The output register refills from memory whenever it is empty or draining.
    assign load  = (!m.tvalid || m.tready) && (mem_count != '0);
    assign occ   = mem_count + CW'(m.tvalid);
    // A pop in the same cycle frees a slot, so a push into a full buffer
    // that is draining is still accepted.
    assign space = (occ < CW'(FIFO_DEPTH)) || pop;
    assign wr    = push_q && space;
    assign drop  = push_q && !space;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= {push_last_q, push_data_q};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            m.tdata   <= 32'd0;
            m.tlast   <= 1'b0;
            m.tvalid  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                m.tdata  <= mem[rd_ptr][31:0];
                m.tlast  <= mem[rd_ptr][32];
                m.tvalid <= 1'b1;
                rd_ptr   <= rd_ptr + AW'(1);
            end else if (pop) begin
                m.tvalid <= 1'b0;
            end
            mem_count <= mem_count + CW'(wr) - CW'(load);
            if (arm_accept) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_syzygy_adc_capture.sv
// ----------------------------------------------------------------------------
// tb_syzygy_adc_capture
//   Directed bench for syzygy_adc_capture. Expected words are queued as each
//   scenario is issued; a monitor pops and compares every transferred word.
// ----------------------------------------------------------------------------
module tb_syzygy_adc_capture;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic          arm;
    logic          sw_trigger;
    logic          trig_en;
    logic [DW-1:0] trig_level;
    logic [15:0]   capture_len;
    logic          busy, done, overflow;
    logic [15:0]   sample_count;
    logic [1:0]    state_dbg;

    logic [32:0]   exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            words_seen = 0;

    syzygy_adc_capture_if bus();

    syzygy_adc_capture #(.DATA_WIDTH(DW), .FIFO_DEPTH(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .arm          (arm),
        .sw_trigger   (sw_trigger),
        .trig_en      (trig_en),
        .trig_level   (trig_level),
        .capture_len  (capture_len),
        .m            (bus),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .sample_count (sample_count),
        .state_dbg    (state_dbg)
    );

    // ------------------------------------------------------- clock / reset
    always #5 clk = ~clk;

    // ------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (reset_n && bus.tvalid && bus.tready) begin
            checks++;
            words_seen++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected: got last=%0b data=%h, expected no word",
                         bus.tlast, bus.tdata);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({bus.tlast, bus.tdata} !== e) begin
                    errors++;
                    $display("FAIL word: got last=%0b data=%h, expected last=%0b data=%h",
                             bus.tlast, bus.tdata, e[32], e[31:0]);
                end
            end
        end
    end

    // -------------------------------------------------------- driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic last, input logic [31:0] data);
        exp_q.push_back({last, data});
    endtask

    task automatic do_arm(input logic [15:0] len);
        arm         = 1'b1;
        capture_len = len;
        tick();
        arm = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic v);
        adc_data  = d;
        adc_valid = v;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.tvalid) && n < 200) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tdata"},  64'(bus.tdata),    64'd0);
        check({tag, "_tvalid"}, 64'(bus.tvalid),   64'd0);
        check({tag, "_tlast"},  64'(bus.tlast),    64'd0);
        check({tag, "_busy"},   64'(busy),         64'd0);
        check({tag, "_done"},   64'(done),         64'd0);
        check({tag, "_ovf"},    64'(overflow),     64'd0);
        check({tag, "_count"},  64'(sample_count), 64'd0);
        check({tag, "_state"},  64'(state_dbg),    64'd0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int base;
        reset_n     = 1'b0;
        adc_data    = '0;
        adc_valid   = 1'b0;
        arm         = 1'b0;
        sw_trigger  = 1'b0;
        trig_en     = 1'b0;
        trig_level  = '0;
        capture_len = 16'd0;
        bus.tready  = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Untriggered ramp, length 8, with output latency check
        trig_en = 1'b0;
        expect_word(1'b0, 32'h0001_0000);
        expect_word(1'b0, 32'h0003_0002);
        expect_word(1'b0, 32'h0005_0004);
        expect_word(1'b1, 32'h0007_0006);
        do_arm(16'd8);
        check("ramp_busy", 64'(busy), 64'd1);
        send(12'd0, 1'b1);
        send(12'd1, 1'b1);
        check("lat_e0", 64'(bus.tvalid), 64'd0);
        send(12'd2, 1'b1);
        check("lat_e1", 64'(bus.tvalid), 64'd0);
        send(12'd3, 1'b1);
        check("lat_e2", 64'(bus.tvalid), 64'd1);
        for (int i = 4; i < 8; i++) send(DW'(i), 1'b1);
        check("ramp_done", 64'(done), 64'd1);
        check("ramp_busy_off", 64'(busy), 64'd0);
        check("ramp_count", 64'(sample_count), 64'd8);
        wait_drain("ramp_drain");
        check("ramp_ovf", 64'(overflow), 64'd0);

        // Threshold trigger: values above level never trigger, then a crossing
        trig_en    = 1'b1;
        trig_level = 12'h800;
        do_arm(16'd4);
        send(12'h900, 1'b1);
        send(12'h901, 1'b1);
        send(12'h902, 1'b1);
        send(12'h850, 1'b1);
        check("thr_still_armed", 64'(state_dbg), 64'd1);
        check("thr_no_count", 64'(sample_count), 64'd0);
        expect_word(1'b0, 32'h0801_0800);
        expect_word(1'b1, 32'h0803_0802);
        send(12'h7FE, 1'b1);
        send(12'h7FF, 1'b1);
        check("thr_below", 64'(state_dbg), 64'd1);
        send(12'h800, 1'b1);
        check("thr_fire_count", 64'(sample_count), 64'd1);
        send(12'h801, 1'b1);
        send(12'h802, 1'b1);
        send(12'h803, 1'b1);
        check("thr_done", 64'(done), 64'd1);
        wait_drain("thr_drain");

        // Odd length with gaps in adc_valid
        trig_en = 1'b0;
        expect_word(1'b0, 32'h0222_0111);
        expect_word(1'b1, 32'h0000_0333);
        do_arm(16'd3);
        send(12'h111, 1'b1);
        send(12'h0AA, 1'b0);
        send(12'h222, 1'b1);
        send(12'h0BB, 1'b0);
        check("odd_mid_count", 64'(sample_count), 64'd2);
        send(12'h333, 1'b1);
        check("odd_count", 64'(sample_count), 64'd3);
        check("odd_done", 64'(done), 64'd1);
        wait_drain("odd_drain");

        // sw_trigger start, and arm ignored during capture
        trig_en    = 1'b1;
        trig_level = 12'h800;
        do_arm(16'd4);
        send(12'h010, 1'b1);
        sw_trigger = 1'b1;
        send(12'h015, 1'b0);
        check("sw_wait_count", 64'(sample_count), 64'd0);
        check("sw_wait_busy", 64'(busy), 64'd1);
        expect_word(1'b0, 32'h0030_0020);
        expect_word(1'b1, 32'h0050_0040);
        send(12'h020, 1'b1);
        sw_trigger = 1'b0;
        check("sw_state", 64'(state_dbg), 64'd2);
        do_arm(16'd2);
        check("arm_ignored_state", 64'(state_dbg), 64'd2);
        send(12'h030, 1'b1);
        send(12'h040, 1'b1);
        check("arm_ignored_busy", 64'(busy), 64'd1);
        send(12'h050, 1'b1);
        check("arm_ignored_count", 64'(sample_count), 64'd4);
        check("arm_ignored_done", 64'(done), 64'd1);
        wait_drain("sw_drain");

        // Zero length: DONE right after arm, no words
        do_arm(16'd0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        base = words_seen;
        repeat (8) tick();
        check("zero_words", 64'(words_seen - base), 64'd0);

        // Backpressure and overflow: 20 words into a 16-word buffer
        trig_en    = 1'b0;
        bus.tready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            expect_word(1'b0, {16'(2 * k + 1), 16'(2 * k)});
        end
        do_arm(16'd40);
        for (int i = 0; i < 40; i++) send(DW'(i), 1'b1);
        repeat (3) tick();
        check("ovf_done", 64'(done), 64'd1);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_count", 64'(sample_count), 64'd40);
        check("ovf_hold_valid", 64'(bus.tvalid), 64'd1);
        check("ovf_hold_data", 64'(bus.tdata), 64'h0001_0000);
        check("ovf_hold_last", 64'(bus.tlast), 64'd0);
        base = words_seen;
        bus.tready = 1'b1;
        wait_drain("ovf_drain");
        repeat (5) tick();
        check("ovf_words", 64'(words_seen - base), 64'd16);

        // Re-arm clears overflow; then reset in the middle of a capture
        bus.tready = 1'b0;
        do_arm(16'd10);
        check("rearm_ovf", 64'(overflow), 64'd0);
        check("rearm_busy", 64'(busy), 64'd1);
        send(12'h0A0, 1'b1);
        send(12'h0A1, 1'b1);
        send(12'h0A2, 1'b1);
        send(12'h0A3, 1'b1);
        check("mid_count", 64'(sample_count), 64'd4);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_all_zero("midrst");
        bus.tready = 1'b1;
        base = words_seen;
        repeat (10) tick();
        check("midrst_words", 64'(words_seen - base), 64'd0);

        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish before 200000 ns");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/syzygy_adc_capture.md
Name: syzygy_adc_capture

Overview:
- Downstream consumer of the SYZYGY ADC sampled on the same `clk` that drives the ADC encode output.
- Block is armed by software. It waits for a software or level-crossing trigger, then captures a fixed number of consecutive ADC samples.
- Samples are packed two per 32-bit word and buffered in a small FIFO. The FIFO feeds an AXI-Stream-style valid/ready output toward the host transfer logic.

Parameters:
- DATA_WIDTH, 12, ADC sample width (≤16); samples are unsigned offset-binary as delivered.
- FIFO_DEPTH, 16, output FIFO depth in 32-bit words; power of two, ≥4.

Ports:
- clk  in  1  system clock; same clock as the ADC encode.
- reset_n  in  1  asynchronous, active-low reset.
- adc_data  in  DATA_WIDTH  ADC sample, registered in the ADC clock domain.
- adc_valid  in  1  sample qualifier; high once the ADC pipeline latency has elapsed.
- arm  in  1  single-cycle arm pulse.
- sw_trigger  in  1  software trigger, level-sensitive while ARMED.
- trig_en  in  1  1 = wait for trigger; 0 = start on the first valid sample.
- trig_level  in  DATA_WIDTH  threshold for rising-crossing trigger.
- capture_len  in  16  number of samples to capture; latched on arm.
- m_tdata  out  32  packed word: bits [15:0] = earlier sample, bits [31:16] = later sample, each zero-extended.
- m_tvalid  out  1  output word valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  high on the final word of a capture.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- overflow  out  1  sticky; a packed word was dropped because the FIFO was full.
- sample_count  out  16  samples taken in the current capture.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State = IDLE; FIFO emptied.
  - All outputs 0: m_tdata, m_tvalid, m_tlast, busy, done, overflow, sample_count.
  - Reset mid-capture discards all buffered data; no partial word is emitted afterwards.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE/DONE, arm=1:
  - Latch capture_len; clear overflow, sample_count and the pack register.
  - Next state ARMED; if the latched length is 0, next state DONE instead.
- arm while ARMED or CAPTURE: ignored.
- Transitions out of ARMED:
  - trig_en=0: first cycle with adc_valid=1 → CAPTURE.
  - trig_en=1: a valid cycle with sw_trigger=1 → CAPTURE.
  - trig_en=1: a rising crossing → CAPTURE. A rising crossing is prev_valid_sample < trig_level and adc_data ≥ trig_level, both valid while ARMED.
  - The triggering sample is sample 0 and is counted in that same cycle.
  - The first valid sample after entering ARMED cannot trigger by crossing, because there is no previous sample; sw_trigger can still trigger it.
- Sampling rule in CAPTURE: each cycle with adc_valid=1 takes one sample and increments sample_count. Cycles with adc_valid=0 are skipped and do not break the capture.
- Packing:
  - Even-index sample goes to the low half of the pack register.
  - Odd-index sample completes the word, which is pushed to the FIFO on the next edge.
  - Odd capture_len: the final word has [31:16]=0.
- Capture end: when sample_count reaches the latched length, the final word is pushed with the tlast flag set, and the state moves to DONE in the same cycle as that push.
- FIFO full at push:
  - The word is dropped and overflow is set (sticky until the next arm).
  - Capture continues time-contiguously; sample_count still advances.
  - If the dropped word is the last one, no tlast is emitted.
- Output handshake:
  - The word transfers on m_tvalid & m_tready.
  - m_tdata and m_tlast are held stable while m_tvalid=1 and m_tready=0.
  - The FIFO continues to drain in DONE and IDLE.
- Latency: with the FIFO empty, m_tvalid rises 2 edges after the edge that samples the word's second sample.
- Simultaneous FIFO push and pop when full: the pop frees a slot, so the push is accepted and there is no overflow.
- Status outputs: busy = ARMED | CAPTURE; done = DONE; both are registered.

Test Plan:
- Reset mid-capture: arm, start capture, pulse reset_n low for 1 cycle → all outputs 0, FIFO empty, state IDLE, no words afterwards.
- Untriggered capture: trig_en=0, capture_len=8, m_tready=1, ramp 0,1,2,… with adc_valid=1 → 4 words 0x0001_0000, 0x0003_0002, 0x0005_0004, 0x0007_0006; m_tlast on the 4th; done=1; overflow=0.
- Threshold trigger: trig_en=1, trig_level=0x800, samples 0x7FE, 0x7FF, 0x800, 0x801, …, capture_len=4 → first word 0x0801_0800; a sample sequence that stays above 0x800 never triggers.
- Odd length with gaps: capture_len=3, adc_valid toggled 1/0 → 2 words, the second with upper half 0x0000 plus m_tlast; sample_count=3.
- Backpressure and overflow:
  - m_tready=0, FIFO_DEPTH=16, capture_len=40 → first 16 words retained, remaining 4 dropped, overflow=1, no tlast.
  - Releasing m_tready → exactly 16 words drain.
  - Re-arm → overflow=0.
- Control corner cases:
  - capture_len=0 → DONE one cycle after arm, no words.
  - arm pulsed during CAPTURE → ignored, capture_len unchanged.
  - sw_trigger with trig_en=1 starts capture on the next valid sample.
